// File: rtl/mips_wb_pkg.sv
// Shared types and widths for the MIPS writeback/commit stage.
package mips_wb_pkg;

    typedef enum logic {
        IDLE,
        CP0_WAIT
    } wb_state_t;

    localparam int REG_W   = 32;
    localparam int HILO_W  = 64;
    localparam int RADDR_W = 5;

endpackage

// File: rtl/wb_hilo_reg.sv
// Architectural {HI,LO} register with same-cycle bypass of the in-flight value.
module wb_hilo_reg
    import mips_wb_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              fwdSel,
    input  logic [HILO_W-1:0] d,
    output logic [HILO_W-1:0] q,
    output logic [HILO_W-1:0] fwd
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

    assign fwd = fwdSel ? d : q;

endmodule

// File: rtl/wb_commit.sv
// Writeback/commit stage: GPR result select, HI/LO ownership, CP0 req/ack writes.
// Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
module wb_commit
    import mips_wb_pkg::*;
#(
    parameter int CP0_TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               RegWriteW,
    input  logic               MemtoRegW,
    input  logic               hilowriteW,
    input  logic               cp0writeW,
    input  logic [REG_W-1:0]   aluoutW,
    input  logic [REG_W-1:0]   readdataW,
    input  logic [HILO_W-1:0]  hiloresW,
    input  logic [REG_W-1:0]   cp0resW,
    input  logic [RADDR_W-1:0] writeregW,
    input  logic [RADDR_W-1:0] writecp0W,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [REG_W-1:0]   rf_wdata,
    output logic [HILO_W-1:0]  hilo_q,
    output logic [HILO_W-1:0]  hilo_fwd,
    output logic               cp0_req,
    output logic [RADDR_W-1:0] cp0_waddr,
    output logic [REG_W-1:0]   cp0_wdata,
    input  logic               cp0_ack,
    output logic               stallW,
`ifdef WB_RETIRE_CNT_EN
    output logic [31:0]        retire_cnt,
`endif
    output logic               cp0_err
);

    localparam logic [7:0] TMO = 8'(CP0_TIMEOUT);

    wb_state_t  state;
    logic [7:0] count;
    logic       isIdle;
    logic       isWait;

    assign isIdle = (state == IDLE);
    assign isWait = (state == CP0_WAIT);

    assign rf_wdata = MemtoRegW ? readdataW : aluoutW;
    assign rf_waddr = writeregW;
    assign rf_we    = RegWriteW & isIdle & (writeregW != '0);

    // MEM/WB is frozen by stallW, so address/data stay valid throughout WAIT.
    assign cp0_req   = isWait | (isIdle & cp0writeW);
    assign cp0_waddr = writecp0W;
    assign cp0_wdata = cp0resW;

    assign stallW = (isIdle & cp0writeW & ~cp0_ack)
                  | (isWait & ~cp0_ack & (count < TMO));

    wb_hilo_reg uHilo (
        .clk    (clk),
        .reset  (reset),
        .we     (hilowriteW & isIdle),
        .fwdSel (hilowriteW),
        .d      (hiloresW),
        .q      (hilo_q),
        .fwd    (hilo_fwd)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            count   <= '0;
            cp0_err <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (cp0writeW & ~cp0_ack) begin
                        state <= CP0_WAIT;
                        count <= 8'd1;
                    end
                end
                CP0_WAIT: begin
                    if (cp0_ack) begin
                        state <= IDLE;
                    end else if (count >= TMO) begin
                        cp0_err <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic anyWrite;
    assign anyWrite = RegWriteW | hilowriteW | cp0writeW;

    always_ff @(posedge clk) begin
        if (!reset) begin
            retire_cnt <= '0;
        end else if ((isIdle & ~stallW & anyWrite) | (isWait & cp0_ack)) begin
            retire_cnt <= retire_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Bench for wb_commit: directed cases then random transactions vs a per-instruction model.
module tb_wb_commit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWriteW, MemtoRegW, hilowriteW, cp0writeW;
    logic [31:0] aluoutW, readdataW, cp0resW;
    logic [63:0] hiloresW;
    logic [4:0]  writeregW, writecp0W;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [63:0] hilo_q, hilo_fwd;
    logic        cp0_req;
    logic [4:0]  cp0_waddr;
    logic [31:0] cp0_wdata;
    logic        cp0_ack;
    logic        stallW;
    logic        cp0_err;
`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [63:0] mHilo = '0;
    logic        mErr = 1'b0;
    logic [31:0] mRet = '0;

    wb_commit #(.CP0_TIMEOUT(TMO)) dut (
        .clk        (clk),
        .reset      (reset),
        .RegWriteW  (RegWriteW),
        .MemtoRegW  (MemtoRegW),
        .hilowriteW (hilowriteW),
        .cp0writeW  (cp0writeW),
        .aluoutW    (aluoutW),
        .readdataW  (readdataW),
        .hiloresW   (hiloresW),
        .cp0resW    (cp0resW),
        .writeregW  (writeregW),
        .writecp0W  (writecp0W),
        .rf_we      (rf_we),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
        .hilo_q     (hilo_q),
        .hilo_fwd   (hilo_fwd),
        .cp0_req    (cp0_req),
        .cp0_waddr  (cp0_waddr),
        .cp0_wdata  (cp0_wdata),
        .cp0_ack    (cp0_ack),
        .stallW     (stallW),
`ifdef WB_RETIRE_CNT_EN
        .retire_cnt (retire_cnt),
`endif
        .cp0_err    (cp0_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic bubble();
        RegWriteW  = 1'b0;
        MemtoRegW  = 1'b0;
        hilowriteW = 1'b0;
        cp0writeW  = 1'b0;
        cp0_ack    = 1'b0;
        aluoutW    = '0;
        readdataW  = '0;
        hiloresW   = '0;
        cp0resW    = '0;
        writeregW  = '0;
        writecp0W  = '0;
    endtask

    // One instruction held in MEM/WB; k = cycle index at which ack arrives.
    // A CP0 write succeeds iff k <= TMO and stalls for min(k,TMO) cycles.
    task automatic txn(input int k);
        int n;
        n = cp0writeW ? ((k < TMO) ? k : TMO) : 0;
        for (int i = 0; i <= n; i++) begin
            cp0_ack = cp0writeW && (i == k);
            @(negedge clk);
            chk("rf_we", 64'(rf_we), 64'(i == 0 && RegWriteW && writeregW != 0));
            chk("rf_waddr", 64'(rf_waddr), 64'(writeregW));
            chk("rf_wdata", 64'(rf_wdata), 64'(MemtoRegW ? readdataW : aluoutW));
            chk("stallW", 64'(stallW), 64'(i < n));
            chk("cp0_req", 64'(cp0_req), 64'(cp0writeW));
            if (cp0writeW) begin
                chk("cp0_waddr", 64'(cp0_waddr), 64'(writecp0W));
                chk("cp0_wdata", 64'(cp0_wdata), 64'(cp0resW));
            end
            chk("hilo_q", hilo_q, mHilo);
            chk("hilo_fwd", hilo_fwd, hilowriteW ? hiloresW : mHilo);
            chk("cp0_err", 64'(cp0_err), 64'(mErr));
`ifdef WB_RETIRE_CNT_EN
            chk("retire_cnt", 64'(retire_cnt), 64'(mRet));
`endif
            @(posedge clk);
            #1;
            if (i == 0 && hilowriteW) mHilo = hiloresW;
        end
        if (cp0writeW && k > TMO) mErr = 1'b1;
        if (cp0writeW ? (k <= TMO) : (RegWriteW | hilowriteW)) mRet++;
        cp0_ack = 1'b0;
    endtask

    initial begin
        bubble();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stallW", 64'(stallW), 64'd0);
        chk("rst_cp0_req", 64'(cp0_req), 64'd0);
        chk("rst_hilo_q", hilo_q, 64'd0);
        chk("rst_cp0_err", 64'(cp0_err), 64'd0);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;

        // load result to r8
        RegWriteW = 1'b1; MemtoRegW = 1'b1;
        readdataW = 32'hDEADBEEF; aluoutW = 32'h12345678; writeregW = 5'd8;
        txn(0);
        // r0 is never written
        writeregW = 5'd0; MemtoRegW = 1'b0;
        txn(0);
        // HI/LO bypass then commit
        bubble();
        hilowriteW = 1'b1; hiloresW = 64'h1122334455667788;
        txn(0);
        bubble();
        txn(0);
        // CP0 write acked on the fourth cycle
        RegWriteW = 1'b1; writeregW = 5'd3; aluoutW = 32'hCAFE0001;
        cp0writeW = 1'b1; writecp0W = 5'd12; cp0resW = 32'hA5A5A5A5;
        txn(3);
        // CP0 write never acked: timeout, sticky error
        bubble();
        cp0writeW = 1'b1; writecp0W = 5'd9; cp0resW = 32'h0BADF00D;
        txn(1000);
        bubble();
        txn(0);
        txn(0);

        // reset while waiting on CP0
        cp0writeW = 1'b1; writecp0W = 5'd14; cp0resW = 32'h13579BDF;
        @(negedge clk);
        chk("w6_stall", 64'(stallW), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        cp0writeW = 1'b0;
        mHilo = '0; mErr = 1'b0; mRet = '0;
        @(negedge clk);
        chk("w6_cp0_req", 64'(cp0_req), 64'd0);
        chk("w6_stallW", 64'(stallW), 64'd0);
        chk("w6_hilo_q", hilo_q, 64'd0);
        chk("w6_cp0_err", 64'(cp0_err), 64'd0);
        @(posedge clk);
        #1;

        for (int t = 0; t < 300; t++) begin
            RegWriteW  = 1'($urandom_range(0, 1));
            MemtoRegW  = 1'($urandom_range(0, 1));
            hilowriteW = 1'($urandom_range(0, 1));
            cp0writeW  = ($urandom_range(0, 2) == 0);
            aluoutW    = $urandom;
            readdataW  = $urandom;
            hiloresW   = {$urandom, $urandom};
            cp0resW    = $urandom;
            writeregW  = 5'($urandom_range(0, 31));
            writecp0W  = 5'($urandom_range(0, 31));
            txn($urandom_range(0, TMO + 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
